// File: rtl/symbol_receiver_if.sv
// Bundle of the serial-line receive signals.
// Members:
//   Enable      receiver enable (driven towards the receiver)
//   Line_In     serial line, idle high (driven towards the receiver)
//   Data_Out    last complete word
//   Data_Valid  one-cycle strobe when Data_Out updates
//   Frame_Error one-cycle strobe on a malformed symbol or gap timeout
//   Busy        frame in progress
interface symbol_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 Enable;
  logic                 Line_In;
  logic [DATA_BITS-1:0] Data_Out;
  logic                 Data_Valid;
  logic                 Frame_Error;
  logic                 Busy;

  modport master (
    output Enable, Line_In,
    input  Data_Out, Data_Valid, Frame_Error, Busy
  );

  modport slave (
    input  Enable, Line_In,
    output Data_Out, Data_Valid, Frame_Error, Busy
  );
endinterface

// File: rtl/symbol_receiver.sv
// Pulse-symbol line decoder: each 4-cycle symbol (0,1,1,1 = bit 1;
// 0,0,0,1 = bit 0) yields one data bit; DATA_BITS bits are collected
// LSB first into Data_Out with a one-cycle Data_Valid strobe.
// Ports:
//   clk    system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    slave side of symbol_receiver_if (Enable, Line_In in;
//          Data_Out, Data_Valid, Frame_Error, Busy out, all registered)
module symbol_receiver #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned GAP_MAX   = 4
) (
  input  logic              clk,
  input  logic              Reset,
  symbol_receiver_if.slave  bus
);

  localparam int unsigned DW = DATA_BITS;
  localparam int unsigned CW = $clog2(DATA_BITS + 1);
  localparam int unsigned GW = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    C3   = 3'd3,
    GAP  = 3'd4
  } state_t;

  state_t          state, state_n;
  logic            b1, b1_n;
  logic            b2, b2_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [GW-1:0]   gap, gap_n;
  logic [DW-1:0]   sh, sh_n;
  logic [DW-1:0]   dout, dout_n;
  logic            dv, dv_n;
  logic            fe, fe_n;
  logic            busy, busy_n;
  logic [DW-1:0]   sh_set;

  // Shift register with the decoded bit placed at position cnt; the
  // register is always clear above cnt, so OR-ing is sufficient.
  assign sh_set = sh | (DW'(b1) << cnt);

  // State and datapath registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      b1    <= 1'b0;
      b2    <= 1'b0;
      cnt   <= '0;
      gap   <= '0;
      sh    <= '0;
      dout  <= '0;
      dv    <= 1'b0;
      fe    <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      b1    <= b1_n;
      b2    <= b2_n;
      cnt   <= cnt_n;
      gap   <= gap_n;
      sh    <= sh_n;
      dout  <= dout_n;
      dv    <= dv_n;
      fe    <= fe_n;
      busy  <= busy_n;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_n = state;
    b1_n    = b1;
    b2_n    = b2;
    cnt_n   = cnt;
    gap_n   = gap;
    sh_n    = sh;
    dout_n  = dout;
    dv_n    = 1'b0;
    fe_n    = 1'b0;

    if (!bus.Enable) begin
      // Silent abort: no strobes, Data_Out untouched
      state_n = IDLE;
      cnt_n   = '0;
      gap_n   = '0;
      sh_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.Line_In) state_n = C1;
        end
        C1: begin
          b1_n    = bus.Line_In;
          state_n = C2;
        end
        C2: begin
          b2_n    = bus.Line_In;
          state_n = C3;
        end
        C3: begin
          if ((b1 != b2) || !bus.Line_In) begin
            fe_n    = 1'b1;
            cnt_n   = '0;
            gap_n   = '0;
            sh_n    = '0;
            state_n = IDLE;
          end else if (cnt == CW'(DATA_BITS - 1)) begin
            dout_n  = sh_set;
            dv_n    = 1'b1;
            cnt_n   = '0;
            sh_n    = '0;
            state_n = IDLE;
          end else begin
            sh_n    = sh_set;
            cnt_n   = cnt + CW'(1);
            gap_n   = '0;
            state_n = GAP;
          end
        end
        GAP: begin
          if (!bus.Line_In) begin
            state_n = C1;
          end else if (gap == GW'(GAP_MAX - 1)) begin
            // This increment would reach GAP_MAX: timeout
            fe_n    = 1'b1;
            cnt_n   = '0;
            gap_n   = '0;
            sh_n    = '0;
            state_n = IDLE;
          end else begin
            gap_n = gap + GW'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.Data_Out    = dout;
  assign bus.Data_Valid  = dv;
  assign bus.Frame_Error = fe;
  assign bus.Busy        = busy;

endmodule
